// File: rtl/fifo_reader.sv
// fifo_reader: read-side engine for the single-clock BRAM fifo.
// Pops words with the fifo's multi-cycle pop handshake and re-presents them
// as a framed valid/ready stream through a 2-entry skid buffer.
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 4900,
    parameter int CNT_WIDTH  = 13
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_busy,
    output logic                  fifo_pop,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        POP,
        WAIT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] buf0;     // oldest entry, drives m_data
    logic [DATA_WIDTH-1:0] buf1;
    logic [1:0]            buf_cnt;
    logic                  capture;
    logic                  accept;

    // A pop is only issued from POP when no push has started underneath it.
    assign capture  = (state == POP) && !fifo_busy;
    assign fifo_pop = capture;
    assign accept   = m_valid && m_ready;

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf0;
    assign m_last  = m_valid && (word_count == LAST_IDX);

    // Pop sequencer: one pop in flight, SETTLE covers the RAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !fifo_empty && !fifo_busy && (buf_cnt < 2'd2))
                        state <= SETTLE;
                end
                SETTLE: state <= POP;
                POP: begin
                    if (fifo_busy)
                        state <= IDLE;
                    else
                        state <= WAIT;
                end
                WAIT: begin
                    if (!fifo_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid buffer: capture from the fifo and drain to the stream, order preserved.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf0    <= '0;
            buf1    <= '0;
            buf_cnt <= '0;
        end else begin
            case ({capture, accept})
                2'b10: begin
                    if (buf_cnt == 2'd0)
                        buf0 <= fifo_data;
                    else
                        buf1 <= fifo_data;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous write and read: occupancy unchanged, the new
                    // word lands behind whatever remains after the read.
                    if (buf_cnt == 2'd1) begin
                        buf0 <= fifo_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Frame position tracking and end-of-frame pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && (word_count == LAST_IDX);
            if (accept) begin
                if (word_count == LAST_IDX)
                    word_count <= '0;
                else
                    word_count <= word_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: drives fifo_reader from a behavioural single-clock fifo
// model and scoreboards the output stream (FRAME_LEN overridden to 4).
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int FL = 4;
    localparam int CW = 13;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_busy;
    logic          fifo_pop;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [CW-1:0] word_count;
    logic          frame_done;

    fifo_reader #(
        .DATA_WIDTH(DW),
        .FRAME_LEN (FL),
        .CNT_WIDTH (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_busy (fifo_busy),
        .fifo_pop  (fifo_pop),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .word_count(word_count),
        .frame_done(frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Fifo model: push or pop makes the fifo busy for the following cycle,
    // fifo_data is a registered read of the front address.
    logic [DW-1:0] mem [0:63];
    logic [5:0]    wr_ptr;
    logic [5:0]    rd_ptr;
    logic          push_req;
    logic [DW-1:0] push_data;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_busy <= 1'b0;
            fifo_data <= '0;
        end else begin
            fifo_data <= mem[rd_ptr];
            fifo_busy <= 1'b0;
            if (push_req && !fifo_busy) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 6'd1;
                fifo_busy   <= 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr    <= rd_ptr + 6'd1;
                fifo_busy <= 1'b1;
            end
        end
    end

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            n_pops = 0;
    int            n_done = 0;
    int            last_pop = 0;
    int            exp_wc = 0;
    logic          exp_done = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: scoreboard compare on every accepted word plus protocol rules.
    always @(negedge clock) begin
        logic [DW-1:0] e;
        if (reset) begin
            exp_wc     = 0;
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (exp_done || frame_done)
                check("frame_done", 32'(frame_done), 32'(exp_done));
            if (frame_done)
                n_done++;
            exp_done = 1'b0;
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (fifo_pop) begin
                check("pop_busy", 32'(fifo_busy), 32'd0);
                check("pop_empty", 32'(fifo_empty), 32'd0);
                if (n_pops > 0)
                    check("pop_gap_ge5", 32'(cyc - last_pop >= 5), 32'd1);
                n_pops++;
                last_pop = cyc;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream_extra: got word %0h expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_data", 32'(m_data), 32'(e));
                    check("m_last", 32'(m_last), 32'(exp_wc == FL - 1));
                    check("word_count", 32'(word_count), 32'(exp_wc));
                    if (exp_wc == FL - 1) begin
                        exp_wc   = 0;
                        exp_done = 1'b1;
                    end else begin
                        exp_wc++;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Returns at the start of the cycle after the fifo accepted the push.
    task automatic push_word(input logic [DW-1:0] d);
        int   g;
        logic ok;
        g  = 0;
        ok = 1'b0;
        @(posedge clock);
        #1 push_data = d;
        push_req = 1'b1;
        while (!ok && g < 50) begin
            @(negedge clock);
            ok = !fifo_busy;
            @(posedge clock);
            g++;
        end
        #1 push_req = 1'b0;
        if (ok)
            exp_q.push_back(d);
        else
            check("push_timeout", 32'(fifo_busy), 32'd0);
    endtask

    task automatic wait_drain(input int lim);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || m_valid) && g < lim) begin
            @(posedge clock);
            #1;
            g++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    typedef struct {
        int unsigned n;
        int unsigned base;
        int unsigned hold;
        int unsigned hold_pops;
        int unsigned wc_end;
        int unsigned frames;
    } scen_t;

    scen_t scen [4];

    initial begin
        int p0;
        int d0;
        int g;

        scen[0] = '{3, 8'hA1, 0, 0, 3, 0};
        scen[1] = '{5, 8'h10, 60, 2, 1, 1};
        scen[2] = '{9, 8'h20, 0, 0, 1, 2};
        scen[3] = '{4, 8'h40, 30, 2, 0, 1};

        reset     = 1'b1;
        enable    = 1'b0;
        m_ready   = 1'b0;
        push_req  = 1'b0;
        push_data = '0;
        repeat (3) @(negedge clock);
        check("rst_fifo_pop", 32'(fifo_pop), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Streaming, back-pressure and framing scenarios.
        for (int unsigned i = 0; i < 4; i++) begin
            do_reset();
            enable  = 1'b1;
            m_ready = (scen[i].hold == 0);
            p0 = n_pops;
            d0 = n_done;
            for (int unsigned k = 0; k < scen[i].n; k++)
                push_word(8'(scen[i].base + k));
            if (scen[i].hold != 0) begin
                repeat (scen[i].hold) @(posedge clock);
                #1;
                check("hold_pops", 32'(n_pops - p0), 32'(scen[i].hold_pops));
                check("hold_head", 32'(m_data), 32'(scen[i].base));
                m_ready = 1'b1;
            end
            wait_drain(400);
            check("total_pops", 32'(n_pops - p0), 32'(scen[i].n));
            check("frames", 32'(n_done - d0), 32'(scen[i].frames));
            check("wc_end", 32'(word_count), 32'(scen[i].wc_end));
        end

        // Push lands at the end of SETTLE so POP sees fifo_busy and aborts.
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        p0 = n_pops;
        push_word(8'h55);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1 push_data = 8'h66;
        push_req = 1'b1;
        @(posedge clock);
        #1 push_req = 1'b0;
        exp_q.push_back(8'h66);
        @(negedge clock);
        check("abort_no_pop", 32'(fifo_pop), 32'd0);
        wait_drain(200);
        check("abort_pops", 32'(n_pops - p0), 32'd2);

        // Reset while in WAIT with two words buffered.
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        push_word(8'h90);
        wait_drain(200);
        m_ready = 1'b0;
        p0 = n_pops;
        push_word(8'h91);
        push_word(8'h92);
        g = 0;
        while ((n_pops - p0) < 2 && g < 100) begin
            @(posedge clock);
            #1;
            g++;
        end
        check("pre_reset_pops", 32'(n_pops - p0), 32'd2);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_word_count", 32'(word_count), 32'd0);
        check("mid_rst_fifo_pop", 32'(fifo_pop), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        m_ready = 1'b1;
        push_word(8'hC1);
        push_word(8'hC2);
        wait_drain(200);
        check("post_rst_wc", 32'(word_count), 32'd2);

        // enable dropped during SETTLE: that pop still completes, then halt.
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        p0 = n_pops;
        push_word(8'h77);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1 enable = 1'b0;
        wait_drain(200);
        check("settle_drop_pops", 32'(n_pops - p0), 32'd1);
        push_word(8'h88);
        repeat (40) @(posedge clock);
        #1;
        check("halt_pops", 32'(n_pops - p0), 32'd1);
        check("halt_valid", 32'(m_valid), 32'd0);
        enable = 1'b1;
        wait_drain(200);
        check("resume_pops", 32'(n_pops - p0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
